// File: rtl/store_buffer_pkg.sv
// Shared sizing constants and the per-cycle operation encoding for the store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH    = 4;
  localparam int SB_ADDR_W   = 32;
  localparam int SB_DATA_W   = 32;
  localparam int SB_WORD_OFS = 2;

  // Exactly one of these is chosen per cycle; it fixes both the memory-port use and the FIFO update.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_DRAIN,
    OP_MERGE,
    OP_PUSH,
    OP_EVICT,
    OP_LD_HIT,
    OP_LD_MEM,
    OP_LD_STALL
  } sb_op_e;

endpackage

// File: rtl/store_buffer_if.sv
// Upstream access port and data-memory port of the store buffer, seen from the buffer (slave) or its environment (master).
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
);

  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic              MemRead_i;
  logic              MemWrite_i;
  logic              drain_i;
  logic [DATA_W-1:0] data_o;
  logic              stall_o;
  logic              empty_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  addr_i, data_i, MemRead_i, MemWrite_i, drain_i, mem_data_i,
    output data_o, stall_o, empty_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
  );

  modport master (
    output addr_i, data_i, MemRead_i, MemWrite_i, drain_i, mem_data_i,
    input  data_o, stall_o, empty_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
  );

endinterface

// File: rtl/store_buffer_match.sv
// Parallel word-address compare against all valid entries, then one-hot to index.
// Merging keeps at most one entry matching, so OR-ing the indices is a valid encoder.
module store_buffer_match #(
  parameter int DEPTH = 4,
  parameter int KEY_W = 30,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH-1:0][KEY_W-1:0] addr_i,
  input  logic [KEY_W-1:0]            key_i,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o
);

  logic [DEPTH-1:0] match_oh;

  always_comb begin
    match_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_oh[i] = valid_i[i] && (addr_i[i] == key_i);
    end
  end

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_oh[i]) begin
        idx_o = idx_o | IDX_W'(i);
      end
    end
  end

  assign hit_o = |match_oh;

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer: absorbs stores in a FIFO, merges same-word stores, forwards to loads, drains on idle/forced cycles.
// Zero-latency load forwarding; stalls upstream only on a full-buffer load miss or while a forced drain is in progress.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  store_buffer_if.slave bus
);

  localparam int WA_W  = ADDR_W - SB_WORD_OFS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][WA_W-1:0]   addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]             head_q, head_d;
  logic [IDX_W-1:0]             tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [DATA_W-1:0]            rdata_q, rdata_d;

  logic [WA_W-1:0]  key;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             full;
  logic             nonempty;
  logic             push;
  logic             pop;
  sb_op_e           op;

  assign key      = bus.addr_i[ADDR_W-1:SB_WORD_OFS];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign nonempty = (count_q != '0);

  store_buffer_match #(
    .DEPTH (DEPTH),
    .KEY_W (WA_W),
    .IDX_W (IDX_W)
  ) u_match (
    .valid_i (valid_q),
    .addr_i  (addr_q),
    .key_i   (key),
    .hit_o   (hit),
    .idx_o   (hit_idx)
  );

  // A forced drain pre-empts everything; an idle cycle falls through to an opportunistic drain.
  always_comb begin
    op = OP_IDLE;
    if (bus.drain_i && nonempty) begin
      op = OP_DRAIN;
    end else if (bus.MemWrite_i) begin
      if (hit)       op = OP_MERGE;
      else if (full) op = OP_EVICT;
      else           op = OP_PUSH;
    end else if (bus.MemRead_i) begin
      if (hit)       op = OP_LD_HIT;
      else if (full) op = OP_LD_STALL;
      else           op = OP_LD_MEM;
    end else if (nonempty) begin
      op = OP_DRAIN;
    end
  end

  assign pop  = (op == OP_DRAIN) || (op == OP_EVICT) || (op == OP_LD_STALL);
  assign push = (op == OP_PUSH)  || (op == OP_EVICT);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rdata_d = rdata_q;

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // On an eviction head==tail, so the push must land after the pop clears the slot.
    if (push) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = key;
      data_d[tail_q]  = bus.data_i;
      tail_d          = tail_q + 1'b1;
    end
    if (op == OP_MERGE) begin
      data_d[hit_idx] = bus.data_i;
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (op == OP_LD_HIT) begin
      rdata_d = data_q[hit_idx];
    end else if (op == OP_LD_MEM) begin
      rdata_d = bus.mem_data_i;
    end
  end

  always_comb begin
    bus.stall_o     = 1'b0;
    bus.mem_read_o  = 1'b0;
    bus.mem_write_o = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_data_o  = '0;
    bus.data_o      = rdata_q;

    if (pop) begin
      bus.mem_write_o = 1'b1;
      bus.mem_addr_o  = {addr_q[head_q], {SB_WORD_OFS{1'b0}}};
      bus.mem_data_o  = data_q[head_q];
    end

    case (op)
      OP_DRAIN:    bus.stall_o = bus.MemRead_i || bus.MemWrite_i;
      OP_LD_STALL: bus.stall_o = 1'b1;
      OP_LD_HIT:   bus.data_o  = data_q[hit_idx];
      OP_LD_MEM: begin
        bus.mem_read_o = 1'b1;
        bus.mem_addr_o = bus.addr_i;
        bus.data_o     = bus.mem_data_i;
      end
      default: ;
    endcase
  end

  assign bus.empty_o = !nonempty;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, all checked cycle by cycle against a queue-based model.
module tb_store_buffer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if sb_if ();

  store_buffer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (sb_if.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] model_dout = '0;
  int          total = 0;
  int          bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    sb_if.addr_i     = '0;
    sb_if.data_i     = '0;
    sb_if.MemRead_i  = 1'b0;
    sb_if.MemWrite_i = 1'b0;
    sb_if.drain_i    = 1'b0;
    sb_if.mem_data_i = '0;
  endtask

  // One cycle: drive, predict from the model, compare, then commit the model's view of the clock edge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic drn);
    int          j;
    logic [31:0] mdi;
    logic        e_stall, e_empty, e_mw, e_mr;
    logic [31:0] e_ma, e_md;
    ent_t        h;
    @(negedge clk);
    mdi              = $urandom;
    sb_if.addr_i     = a;
    sb_if.data_i     = d;
    sb_if.MemRead_i  = rd;
    sb_if.MemWrite_i = wr;
    sb_if.drain_i    = drn;
    sb_if.mem_data_i = mdi;
    #2;
    j = -1;
    foreach (model_q[k]) if (model_q[k].a[31:2] == a[31:2]) j = k;
    e_empty = (model_q.size() == 0);
    e_stall = 1'b0; e_mw = 1'b0; e_mr = 1'b0; e_ma = '0; e_md = '0;
    if (drn && model_q.size() > 0) begin
      e_stall = rd | wr;
      h = model_q.pop_front(); e_mw = 1'b1; e_ma = h.a; e_md = h.d;
    end else if (wr) begin
      if (j >= 0) model_q[j].d = d;
      else begin
        if (model_q.size() == 4) begin
          h = model_q.pop_front(); e_mw = 1'b1; e_ma = h.a; e_md = h.d;
        end
        model_q.push_back('{a: a, d: d});
      end
    end else if (rd) begin
      if (j >= 0) model_dout = model_q[j].d;
      else if (model_q.size() < 4) begin
        e_mr = 1'b1; e_ma = a; model_dout = mdi;
      end else begin
        e_stall = 1'b1;
        h = model_q.pop_front(); e_mw = 1'b1; e_ma = h.a; e_md = h.d;
      end
    end else if (model_q.size() > 0) begin
      h = model_q.pop_front(); e_mw = 1'b1; e_ma = h.a; e_md = h.d;
    end
    check_val("stall", sb_if.stall_o, e_stall);
    check_val("empty", sb_if.empty_o, e_empty);
    check_val("mem_write", sb_if.mem_write_o, e_mw);
    check_val("mem_read", sb_if.mem_read_o, e_mr);
    check_val("mem_addr", sb_if.mem_addr_o, e_ma);
    check_val("mem_data", sb_if.mem_data_o, e_md);
    check_val("data_o", sb_if.data_o, model_dout);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_empty"}, sb_if.empty_o, 1);
    check_val({tag, "_stall"}, sb_if.stall_o, 0);
    check_val({tag, "_mem_write"}, sb_if.mem_write_o, 0);
    check_val({tag, "_mem_read"}, sb_if.mem_read_o, 0);
    check_val({tag, "_mem_addr"}, sb_if.mem_addr_o, 0);
    check_val({tag, "_mem_data"}, sb_if.mem_data_o, 0);
    check_val({tag, "_data_o"}, sb_if.data_o, 0);
  endtask

  initial begin
    int r;
    set_idle();
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Two stores, then idle drains in order.
    step(0, 1, 32'h04, 32'h11, 0);
    step(0, 1, 32'h08, 32'h22, 0);
    repeat (3) step(0, 0, 0, 0, 0);

    // Forwarding from a buffered store.
    step(0, 1, 32'h10, 32'hAA, 0);
    step(1, 0, 32'h10, 0, 0);
    step(0, 0, 0, 0, 0);

    // Merge then forced drain: one write of the merged value.
    step(0, 1, 32'h20, 32'h1, 0);
    step(0, 1, 32'h20, 32'h2, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Full buffer, store miss evicts head in the same cycle.
    for (int i = 0; i < 4; i++) step(0, 1, 32'(i * 4), 32'h100 + 32'(i), 0);
    step(0, 1, 32'h40, 32'h5, 0);
    // Full buffer, load miss stalls once then reads memory.
    step(1, 0, 32'h60, 0, 0);
    step(1, 0, 32'h60, 0, 0);
    // Access during forced drain is stalled.
    step(0, 1, 32'h70, 32'h7, 1);
    repeat (4) step(0, 0, 0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      step(r >= 4 && r <= 6, r <= 3, 32'($urandom_range(0, 11)) * 4, $urandom,
           $urandom_range(0, 9) == 0);
    end
    repeat (5) step(0, 0, 0, 0, 1);

    // Asynchronous reset with three stores pending.
    step(0, 1, 32'h80, 32'hA1, 0);
    step(0, 1, 32'h84, 32'hA2, 0);
    step(0, 1, 32'h88, 32'hA3, 0);
    @(posedge clk);
    #2;
    set_idle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_q.delete();
    model_dout = '0;
    repeat (2) begin
      @(negedge clk);
      check_val("midrst_hold_mem_write", sb_if.mem_write_o, 0);
    end
    rst_n = 1'b1;
    repeat (4) step(0, 0, 0, 0, 0);
    step(1, 0, 32'h80, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
